// File: rtl/regfile_rd_arbiter_pkg.sv
// Shared constants and helpers for the register-file read-port arbiter
// and its sibling port arbiters.
package regfile_rd_arbiter_pkg;

  // Register index width, matching the 5-bit select of mux_32to1.
  localparam int RF_ADDR_W = 5;

  // Register data width.
  localparam int RF_DATA_W = 32;

  // MIPS $zero: always reads as zero, whatever the array holds.
  localparam logic [4:0] RF_ZERO_REG = 5'd0;

  // Next round-robin start position after index idx has been granted.
  // The wrap is written out so non-power-of-2 requester counts work.
  function automatic int rr_next(input int idx, input int n);
    if (idx >= n - 32'sd1) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/mux_32to1.sv
// 32-to-1 register read multiplexer; z follows s combinationally.
module mux_32to1 (
  input  logic [31:0] i0,  input  logic [31:0] i1,  input  logic [31:0] i2,  input  logic [31:0] i3,
  input  logic [31:0] i4,  input  logic [31:0] i5,  input  logic [31:0] i6,  input  logic [31:0] i7,
  input  logic [31:0] i8,  input  logic [31:0] i9,  input  logic [31:0] i10, input  logic [31:0] i11,
  input  logic [31:0] i12, input  logic [31:0] i13, input  logic [31:0] i14, input  logic [31:0] i15,
  input  logic [31:0] i16, input  logic [31:0] i17, input  logic [31:0] i18, input  logic [31:0] i19,
  input  logic [31:0] i20, input  logic [31:0] i21, input  logic [31:0] i22, input  logic [31:0] i23,
  input  logic [31:0] i24, input  logic [31:0] i25, input  logic [31:0] i26, input  logic [31:0] i27,
  input  logic [31:0] i28, input  logic [31:0] i29, input  logic [31:0] i30, input  logic [31:0] i31,
  input  logic [4:0]  s,
  output logic [31:0] z
);

  // Select one of the 32 register values.
  always_comb begin
    z = 32'h0000_0000;
    case (s)
      5'd0:  z = i0;
      5'd1:  z = i1;
      5'd2:  z = i2;
      5'd3:  z = i3;
      5'd4:  z = i4;
      5'd5:  z = i5;
      5'd6:  z = i6;
      5'd7:  z = i7;
      5'd8:  z = i8;
      5'd9:  z = i9;
      5'd10: z = i10;
      5'd11: z = i11;
      5'd12: z = i12;
      5'd13: z = i13;
      5'd14: z = i14;
      5'd15: z = i15;
      5'd16: z = i16;
      5'd17: z = i17;
      5'd18: z = i18;
      5'd19: z = i19;
      5'd20: z = i20;
      5'd21: z = i21;
      5'd22: z = i22;
      5'd23: z = i23;
      5'd24: z = i24;
      5'd25: z = i25;
      5'd26: z = i26;
      5'd27: z = i27;
      5'd28: z = i28;
      5'd29: z = i29;
      5'd30: z = i30;
      5'd31: z = i31;
      default: z = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/regfile_rd_arbiter_chk.sv
// Protocol checks on the arbiter outputs; kept apart from the datapath.
module regfile_rd_arbiter_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N_REQ-1:0] gnt,
  input logic [N_REQ-1:0] rvalid
);

  // At most one requester granted per cycle.
  gnt_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  // At most one data-valid pulse per cycle.
  rvalid_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid));

  // Read data always belongs to the requester granted one cycle earlier.
  rvalid_follows_gnt_a : assert property (@(posedge clk) disable iff (!rst_n) rvalid == $past(gnt));

endmodule

// File: rtl/regfile_rd_arbiter_rr_pick.sv
// Rotating first-one search: starting at ptr and wrapping modulo N_REQ,
// the first asserted request wins. Purely combinational so the write-port
// and memory-port arbiters can reuse it unchanged.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_masked,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [PTR_W-1:0] idx_s;

  // Walk the requesters in priority order ptr, ptr+1, ... and take the first.
  always_comb begin
    win   = '0;
    any   = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!any && req_masked[idx_s]) begin
        win[idx_s] = 1'b1;
        any        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing one register-file read port (mux_32to1)
// among N_REQ requesters. Request-to-data latency is two cycles: the
// grant and mux select are registered together, then the mux output is
// captured one cycle later with a matching per-requester valid pulse.
module regfile_rd_arbiter
  import regfile_rd_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       sel,
  input  logic [DATA_W-1:0]       mux_z,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  ptr_nxt_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic [N_REQ-1:0]  req_masked_s;
  logic [N_REQ-1:0]  win_s;
  logic              any_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] rdata_nxt_s;

  // The requester holding the current grant may still show req this cycle;
  // masking it stops a single request from being granted twice.
  assign req_masked_s = req & ~gnt;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_masked (req_masked_s),
    .ptr        (ptr_r),
    .win        (win_s),
    .any        (any_s)
  );

  // Winner index, its register address, and the pointer value after it.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_s[i]) begin
        win_idx_s = PTR_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
    win_addr_s = addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
    ptr_nxt_s  = PTR_W'(rr_next(int'(win_idx_s), N_REQ));
  end

  // Read data to capture: register 0 is hard-wired zero.
  always_comb begin
    if (sel == RF_ZERO_REG) begin
      rdata_nxt_s = '0;
    end else begin
      rdata_nxt_s = mux_z;
    end
  end

  // Grant/select stage and data-capture stage; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      sel    <= '0;
      ptr_r  <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      gnt    <= win_s;
      rvalid <= gnt;
      if (any_s) begin
        sel   <= win_addr_s;
        ptr_r <= ptr_nxt_s;
      end
      if (|gnt) begin
        rdata <= rdata_nxt_s;
      end
    end
  end

  regfile_rd_arbiter_chk #(
    .N_REQ (N_REQ)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .gnt    (gnt),
    .rvalid (rvalid)
  );

endmodule
